// File: rtl/s27_bist_pkg.sv
// Shared constants, state encoding and next-value helpers for the s27 BIST controller.
package s27_bist_pkg;

    localparam int unsigned SIG_W  = 16;
    localparam int unsigned LFSR_W = 4;
    localparam int unsigned PCNT_W = 8;
    localparam int unsigned FCNT_W = 4;

    localparam logic [SIG_W-1:0] MISR_POLY = 16'h1021;

    // Feedback taps of the 4-bit maximal-length LFSR (period 15).
    localparam int unsigned LFSR_TAP_HI = 3;
    localparam int unsigned LFSR_TAP_LO = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FLUSH = 2'd1,
        ST_RUN   = 2'd2,
        ST_DONE  = 2'd3
    } bist_state_e;

    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
        return {v[LFSR_W-2:0], v[LFSR_TAP_HI] ^ v[LFSR_TAP_LO]};
    endfunction

    function automatic logic [SIG_W-1:0] misr_next(input logic [SIG_W-1:0] s, input logic d);
        logic fb;
        fb = s[SIG_W-1] ^ d;
        return {s[SIG_W-2:0], 1'b0} ^ (fb ? MISR_POLY : '0);
    endfunction

endpackage

// File: rtl/s27_misr.sv
// Single-input 16-bit signature register compacting the circuit-under-test response.
module s27_misr
    import s27_bist_pkg::*;
(
    input  logic             CK,
    input  logic             RN,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [SIG_W-1:0] sig
);

    always_ff @(posedge CK) begin
        if (!RN || clr) begin
            sig <= '0;
        end else if (en) begin
            sig <= misr_next(sig, din);
        end
    end

endmodule

// File: rtl/s27_bist_ctrl.sv
// BIST session controller: flush, LFSR-driven stimulus to the s27 core, MISR compaction, pass/fail.
module s27_bist_ctrl
    import s27_bist_pkg::*;
#(
    parameter int unsigned       N_PATTERNS    = 255,
    parameter int unsigned       FLUSH_CYCLES  = 3,
    parameter logic [3:0]        FLUSH_PATTERN = 4'b0000,
    parameter logic [3:0]        LFSR_SEED     = 4'b0001,
    parameter logic [SIG_W-1:0]  SIG_GOLDEN    = 16'h0000
) (
    input  logic             CK,
    input  logic             RN,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] sig,
    output logic             dut_g0,
    output logic             dut_g1,
    output logic             dut_g2,
    output logic             dut_g3,
    input  logic             dut_g17
);

    localparam logic [FCNT_W-1:0] FLUSH_LAST = FCNT_W'(FLUSH_CYCLES - 1);
    localparam logic [PCNT_W-1:0] RUN_LAST   = PCNT_W'(N_PATTERNS - 1);

    bist_state_e         state;
    bist_state_e         state_nxt;
    logic [LFSR_W-1:0]   lfsr;
    logic [LFSR_W-1:0]   lfsr_nxt;
    logic [FCNT_W-1:0]   fcnt;
    logic [PCNT_W-1:0]   pcnt;
    logic [3:0]          stim;
    logic                accept;
    logic                run_en;
    logic                run_last;

    always_ff @(posedge CK) begin
        if (!RN) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        run_en    = 1'b0;
        run_last  = 1'b0;
        case (state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    accept    = 1'b1;
                    state_nxt = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                if (fcnt == FLUSH_LAST) begin
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                run_en = 1'b1;
                if (pcnt == RUN_LAST) begin
                    run_last  = 1'b1;
                    state_nxt = ST_DONE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign lfsr_nxt = run_en ? lfsr_step(lfsr) : lfsr;

    // Stimulus is registered from the value the LFSR will hold next, so the
    // applied pattern and the MISR sample always refer to the same LFSR state.
    always_ff @(posedge CK) begin
        if (!RN) begin
            lfsr <= LFSR_SEED;
            fcnt <= '0;
            pcnt <= '0;
            pass <= 1'b0;
            stim <= FLUSH_PATTERN;
        end else begin
            if (accept) begin
                lfsr <= LFSR_SEED;
                fcnt <= '0;
                pcnt <= '0;
                pass <= 1'b0;
            end else begin
                lfsr <= lfsr_nxt;
                if (state == ST_FLUSH) begin
                    fcnt <= fcnt + 1'b1;
                end
                if (run_en) begin
                    pcnt <= pcnt + 1'b1;
                end
                if (run_last) begin
                    pass <= (misr_next(sig, dut_g17) == SIG_GOLDEN);
                end
            end
            stim <= (state_nxt == ST_RUN) ? lfsr_nxt : FLUSH_PATTERN;
        end
    end

    s27_misr u_misr (
        .CK  (CK),
        .RN  (RN),
        .clr (accept),
        .en  (run_en),
        .din (dut_g17),
        .sig (sig)
    );

    assign busy   = (state == ST_FLUSH) || (state == ST_RUN);
    assign done   = (state == ST_DONE);
    assign dut_g0 = stim[0];
    assign dut_g1 = stim[1];
    assign dut_g2 = stim[2];
    assign dut_g3 = stim[3];

endmodule

// File: tb/tb_s27_bist_ctrl.sv
// Randomized self-checking bench for s27_bist_ctrl against a timeline-based session model.
module tb_s27_bist_ctrl;

    localparam int unsigned N_PAT   = 20;
    localparam int unsigned FLUSH_N = 3;
    localparam logic [3:0]  FPAT    = 4'b1010;
    localparam logic [15:0] GOLDEN  = 16'h0000;

    logic        CK = 1'b0;
    logic        RN = 1'b0;
    logic        start = 1'b0;
    logic        dut_g17 = 1'b0;
    logic        busy, done, pass;
    logic [15:0] sig;
    logic        dut_g0, dut_g1, dut_g2, dut_g3;

    int n_chk  = 0;
    int n_fail = 0;

    // Maximal-length sequence from seed 0001, written out as {g3..g0}.
    logic [3:0] pat_tbl [15] = '{4'b0001, 4'b0010, 4'b0100, 4'b1001, 4'b0011,
                                 4'b0110, 4'b1101, 4'b1010, 4'b0101, 4'b1011,
                                 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};

    s27_bist_ctrl #(
        .N_PATTERNS    (N_PAT),
        .FLUSH_CYCLES  (FLUSH_N),
        .FLUSH_PATTERN (FPAT),
        .LFSR_SEED     (4'b0001),
        .SIG_GOLDEN    (GOLDEN)
    ) dut (
        .CK      (CK),
        .RN      (RN),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .pass    (pass),
        .sig     (sig),
        .dut_g0  (dut_g0),
        .dut_g1  (dut_g1),
        .dut_g2  (dut_g2),
        .dut_g3  (dut_g3),
        .dut_g17 (dut_g17)
    );

    always #5 CK = ~CK;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CK);
        #1;
    endtask

    // Signature update: shift left, fold in the polynomial when the feedback bit is set.
    function automatic int unsigned ref_misr(input int unsigned s, input bit d);
        int unsigned fb;
        fb = ((s >> 15) & 1) ^ int'(d);
        return ((s << 1) & 32'hFFFF) ^ (fb != 0 ? 32'h1021 : 32'h0);
    endfunction

    task automatic session_begin();
        start = 1'b1;
        step();
    endtask

    // Cycle c counts from 1 = first cycle after the accepting edge.
    // mode: 0 response tied 0, 1 tied 1, 2 random.  policy: 0 start low,
    // 1 random start while busy, 2 start held high.  abort_at: cycle to pulse RN.
    task automatic run_body(input int mode, input int policy, input int abort_at,
                            output int unsigned fin_sig);
        int unsigned s;
        bit          g;
        logic [3:0]  exp_dut;
        s = 0;
        fin_sig = 0;
        for (int c = 1; c <= int'(N_PAT) + 4; c++) begin
            if (c == abort_at) begin
                RN = 1'b0;
                step();
                RN = 1'b1;
                start = 1'b0;
                chk("abort_busy", 16'(busy), 16'd0);
                chk("abort_done", 16'(done), 16'd0);
                chk("abort_pass", 16'(pass), 16'd0);
                chk("abort_sig", sig, 16'h0000);
                chk("abort_dut", 16'({dut_g3, dut_g2, dut_g1, dut_g0}), 16'(FPAT));
                return;
            end
            if (c >= 4 && c <= int'(N_PAT) + 3) exp_dut = pat_tbl[(c - 4) % 15];
            else                                 exp_dut = FPAT;
            if (c <= int'(N_PAT) + 3) begin
                chk("busy", 16'(busy), 16'd1);
                chk("done", 16'(done), 16'd0);
                chk("pass_clr", 16'(pass), 16'd0);
            end else begin
                chk("done_end", 16'(done), 16'd1);
                chk("busy_end", 16'(busy), 16'd0);
                chk("pass_end", 16'(pass), 16'(s == 32'(GOLDEN)));
            end
            chk("dut", 16'({dut_g3, dut_g2, dut_g1, dut_g0}), 16'(exp_dut));
            chk("sig", sig, 16'(s));
            if (mode == 1 && c == 5) chk("sig_first", sig, 16'h1021);
            if (mode == 1 && c == 6) chk("sig_second", sig, 16'h3063);

            if (mode == 0)      g = 1'b0;
            else if (mode == 1) g = 1'b1;
            else                g = 1'($urandom_range(0, 1));
            dut_g17 = g;
            if (policy == 2)                          start = 1'b1;
            else if (policy == 1 && c <= int'(N_PAT) + 3) start = 1'($urandom_range(0, 1));
            else                                      start = 1'b0;

            if (c <= int'(N_PAT) + 3) begin
                step();
                if (c >= 4) s = ref_misr(s, g);
            end
        end
        fin_sig = s;
    endtask

    task automatic hold_done(input int cycles, input int unsigned exp_sig);
        for (int i = 0; i < cycles; i++) begin
            dut_g17 = 1'($urandom_range(0, 1));
            step();
            chk("hold_done", 16'(done), 16'd1);
            chk("hold_busy", 16'(busy), 16'd0);
            chk("hold_pass", 16'(pass), 16'(exp_sig == 32'(GOLDEN)));
            chk("hold_sig", sig, 16'(exp_sig));
            chk("hold_dut", 16'({dut_g3, dut_g2, dut_g1, dut_g0}), 16'(FPAT));
        end
    endtask

    initial begin
        int unsigned fs;
        RN = 1'b0;
        start = 1'b1;
        repeat (3) step();
        chk("rst_busy", 16'(busy), 16'd0);
        chk("rst_done", 16'(done), 16'd0);
        chk("rst_pass", 16'(pass), 16'd0);
        chk("rst_sig", sig, 16'h0000);
        chk("rst_dut", 16'({dut_g3, dut_g2, dut_g1, dut_g0}), 16'(FPAT));
        RN = 1'b1;
        start = 1'b0;
        step();
        chk("idle_busy", 16'(busy), 16'd0);
        chk("idle_dut", 16'({dut_g3, dut_g2, dut_g1, dut_g0}), 16'(FPAT));

        session_begin();
        run_body(0, 0, 0, fs);
        hold_done(3, fs);

        session_begin();
        run_body(1, 0, 0, fs);
        hold_done(2, fs);

        for (int k = 0; k < 3; k++) begin
            session_begin();
            run_body(2, 1, 0, fs);
            hold_done(1, fs);
        end

        session_begin();
        run_body(2, 0, 9, fs);
        step();
        chk("post_abort_busy", 16'(busy), 16'd0);
        session_begin();
        run_body(0, 0, 0, fs);

        session_begin();
        run_body(2, 2, 0, fs);
        step();
        run_body(2, 0, 0, fs);
        hold_done(1, fs);

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
